biriscv_trace_encoder: RTL

- Compresses the retired-instruction stream (valid, pc) from the core's writeback stage into a packet trace for a debug host.
- A packet is emitted only on program-flow discontinuities, run-length saturation, explicit flush, or resynchronisation. Sequential retirements are counted, not sent.
- Packets are queued in a small FIFO and drained over a valid/accept handshake.
- Sits beside the core's simulation trace monitor on the same writeback tap.

---
 rtl/biriscv_trace_encoder_pkg.sv | 42 ++++
 rtl/biriscv_trace_encoder_if.sv | 16 +
 rtl/biriscv_trace_fifo.sv | 59 +++++
 rtl/biriscv_trace_encoder.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/biriscv_trace_encoder_pkg.sv
// rtl/biriscv_trace_encoder_pkg.sv - shared packet types, field positions and helpers
// Purpose: packet type codes, field layout of the 48-bit trace packet,
//          encoder state encoding and a packing helper.
// Ports:   none (package).
package biriscv_trace_encoder_pkg;

  localparam int TRACE_PKT_W = 48;

  localparam logic [1:0] TRACE_PKT_SYNC   = 2'd0;
  localparam logic [1:0] TRACE_PKT_BRANCH = 2'd1;
  localparam logic [1:0] TRACE_PKT_COUNT  = 2'd2;
  localparam logic [1:0] TRACE_PKT_OSYNC  = 2'd3;

  localparam int TRACE_ADDR_LSB  = 0;
  localparam int TRACE_ADDR_MSB  = 31;
  localparam int TRACE_COUNT_LSB = 32;
  localparam int TRACE_COUNT_MSB = 45;
  localparam int TRACE_TYPE_LSB  = 46;
  localparam int TRACE_TYPE_MSB  = 47;

  // Largest run count a packet can carry; reaching it forces a COUNT packet.
  localparam logic [13:0] TRACE_RUN_MAX = 14'h3FFF;

  typedef enum logic {
    ST_NEED_SYNC = 1'b0,
    ST_TRACK     = 1'b1
  } trace_state_t;

  function automatic logic [TRACE_PKT_W-1:0] trace_pack(
    input logic [1:0]  pkt_type,
    input logic [13:0] pkt_count,
    input logic [31:0] pkt_addr
  );
    logic [TRACE_PKT_W-1:0] w_pkt;
    w_pkt = '0;
    w_pkt[TRACE_TYPE_MSB:TRACE_TYPE_LSB]   = pkt_type;
    w_pkt[TRACE_COUNT_MSB:TRACE_COUNT_LSB] = pkt_count;
    w_pkt[TRACE_ADDR_MSB:TRACE_ADDR_LSB]   = pkt_addr;
    return w_pkt;
  endfunction

endpackage

// File: rtl/biriscv_trace_encoder_if.sv
// rtl/biriscv_trace_encoder_if.sv - packet output handshake interface
// Purpose: groups the packet stream towards the debug host.
// Signals: pkt_valid_o (FIFO head valid), pkt_data_o (head packet),
//          pkt_accept_i (host consumes head this cycle).
// Modports: master = encoder side, slave = host side.
interface biriscv_trace_encoder_if;
  import biriscv_trace_encoder_pkg::*;

  logic                   pkt_valid_o;
  logic [TRACE_PKT_W-1:0] pkt_data_o;
  logic                   pkt_accept_i;

  modport master (output pkt_valid_o, output pkt_data_o, input pkt_accept_i);
  modport slave  (input pkt_valid_o, input pkt_data_o, output pkt_accept_i);

endinterface

// File: rtl/biriscv_trace_fifo.sv
// rtl/biriscv_trace_fifo.sv - show-ahead packet FIFO
// Purpose: small show-ahead FIFO; head is presented combinationally and reads
//          as zero when empty. Pushes while full are ignored (caller detects).
// Ports:   clk_i, rst_i (async, active-high), push_i/data_i (write side),
//          pop_i (consume head), data_o/valid_o (head), full_o.
module biriscv_trace_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign valid_o   = (r_count != '0);
  assign full_o    = (r_count == CNT_FULL);
  // Full is judged on occupancy before this cycle's pop.
  assign w_do_push = push_i & ~full_o;
  assign w_do_pop  = pop_i & valid_o;
  assign data_o    = valid_o ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/biriscv_trace_encoder.sv
// rtl/biriscv_trace_encoder.sv - retired-instruction trace compressor
// Purpose: turns the writeback (valid, pc) stream into SYNC/BRANCH/COUNT/OSYNC
//          packets, counting sequential retirements instead of sending them.
// Ports:   clk_i, rst_i (async, active-high), valid_i/pc_i (retire tap),
//          enable_i (trace enable, low re-arms), flush_i (emit pending run),
//          pkt_if (packet handshake, master), overflow_o (sticky drop flag).
module biriscv_trace_encoder
  import biriscv_trace_encoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           valid_i,
  input  logic [31:0]                    pc_i,
  input  logic                           enable_i,
  input  logic                           flush_i,
  biriscv_trace_encoder_if.master        pkt_if,
  output logic                           overflow_o
);

  trace_state_t           r_state, w_state_n;
  logic [31:0]            r_exp_pc, w_exp_pc_n;
  logic [13:0]            r_run, w_run_n, w_run_inc;
  logic                   r_flush_pend, w_flush_pend_n;
  logic                   r_lost, w_lost_n;
  logic                   r_overflow, w_overflow_n;
  logic                   w_flush_req;
  logic                   w_push;
  logic [TRACE_PKT_W-1:0] w_push_data;
  logic                   w_full;

  always_comb begin
    w_state_n      = r_state;
    w_exp_pc_n     = r_exp_pc;
    w_run_n        = r_run;
    w_flush_pend_n = r_flush_pend;
    w_lost_n       = r_lost;
    w_overflow_n   = r_overflow;
    w_push         = 1'b0;
    w_push_data    = '0;
    // A flush arriving this cycle is honoured together with any pending one.
    w_flush_req    = r_flush_pend | flush_i;
    w_run_inc      = r_run + 14'd1;

    if (!enable_i) begin
      w_state_n      = ST_NEED_SYNC;
      w_run_n        = '0;
      w_flush_pend_n = 1'b0;
      w_lost_n       = 1'b0;
      w_overflow_n   = 1'b0;
    end else begin
      case (r_state)
        ST_NEED_SYNC: begin
          w_flush_pend_n = 1'b0;
          if (valid_i) begin
            w_push      = 1'b1;
            w_push_data = trace_pack(r_lost ? TRACE_PKT_OSYNC : TRACE_PKT_SYNC, 14'd0, pc_i);
            w_state_n   = ST_TRACK;
            w_exp_pc_n  = pc_i + 32'd4;
            w_run_n     = '0;
            w_lost_n    = 1'b0;
          end
        end
        ST_TRACK: begin
          if (valid_i) begin
            w_exp_pc_n     = pc_i + 32'd4;
            w_flush_pend_n = w_flush_req;
            if (pc_i == r_exp_pc) begin
              if (w_run_inc == TRACE_RUN_MAX) begin
                w_push      = 1'b1;
                w_push_data = trace_pack(TRACE_PKT_COUNT, TRACE_RUN_MAX, pc_i);
                w_run_n     = '0;
              end else begin
                w_run_n = w_run_inc;
              end
            end else begin
              w_push      = 1'b1;
              w_push_data = trace_pack(TRACE_PKT_BRANCH, r_run, pc_i);
              w_run_n     = '0;
            end
          end else begin
            w_flush_pend_n = 1'b0;
            if (w_flush_req && (r_run != '0)) begin
              // exp_pc-4 is the last retired PC of the run.
              w_push      = 1'b1;
              w_push_data = trace_pack(TRACE_PKT_COUNT, r_run, r_exp_pc - 32'd4);
              w_run_n     = '0;
            end
          end
        end
        default: w_state_n = ST_NEED_SYNC;
      endcase

      // A dropped packet breaks the trace: force a resync that will be
      // reported as OSYNC.
      if (w_push && w_full) begin
        w_state_n    = ST_NEED_SYNC;
        w_run_n      = '0;
        w_lost_n     = 1'b1;
        w_overflow_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_NEED_SYNC;
      r_exp_pc     <= '0;
      r_run        <= '0;
      r_flush_pend <= 1'b0;
      r_lost       <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_exp_pc     <= w_exp_pc_n;
      r_run        <= w_run_n;
      r_flush_pend <= w_flush_pend_n;
      r_lost       <= w_lost_n;
      r_overflow   <= w_overflow_n;
    end
  end

  assign overflow_o = r_overflow;

  biriscv_trace_fifo #(
    .WIDTH (TRACE_PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  (w_push_data),
    .pop_i   (pkt_if.pkt_accept_i),
    .data_o  (pkt_if.pkt_data_o),
    .valid_o (pkt_if.pkt_valid_o),
    .full_o  (w_full)
  );

endmodule
